// File: rtl/wb_trace_fifo.sv
// Trace FIFO behind the mips core: queues committed GRF write-back and DM store
// events in program order and drains one record per cycle over valid/ready.
module wb_trace_fifo #(
    parameter int DEPTH       = 16,
    parameter bit FILTER_ZERO = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wdata,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_type,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = AW + 2;

    typedef struct packed {
        logic        typ;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    rec_t            mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic            grf_ev;
    logic            deq;
    logic [SW-1:0]   space;
    logic            adm_g, adm_d;
    logic [1:0]      n_adm, n_drop;
    logic            wr0, wr1;
    logic [AW-1:0]   tail1;
    rec_t            rec_g, rec_d, rec0;
    rec_t            head_rec;

    always_comb begin
        rec_g    = '{typ: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wdata};
        rec_d    = '{typ: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};
        grf_ev   = grf_we && !(FILTER_ZERO && (grf_addr == 5'd0));
        deq      = (count_q != '0) && out_ready;
        // A slot freed by this cycle's dequeue can be refilled in the same cycle.
        space    = SW'(DEPTH) - SW'(count_q) + SW'(deq);
        // The W-stage GRF event is older than the M-stage store, so it claims space first.
        adm_g    = grf_ev && (space >= SW'(1));
        adm_d    = dm_we && (space >= (adm_g ? SW'(2) : SW'(1)));
        n_adm    = {1'b0, adm_g} + {1'b0, adm_d};
        n_drop   = {1'b0, grf_ev && !adm_g} + {1'b0, dm_we && !adm_d};
        wr0      = adm_g || adm_d;
        wr1      = adm_g && adm_d;
        rec0     = adm_g ? rec_g : rec_d;
        tail1    = tail_q + AW'(1);
        tail_d   = tail_q + AW'(n_adm);
        head_d   = head_q + AW'(deq);
        count_d  = count_q + CW'(n_adm) - CW'(deq);
        ovf_d    = ovf_q | (n_drop != 2'd0);
        drop_d   = sat_add(drop_q, n_drop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Record storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (reset && wr0) mem_q[tail_q] <= rec0;
        if (reset && wr1) mem_q[tail1]  <= rec_d;
    end

    assign head_rec  = mem_q[head_q];
    assign out_valid = (count_q != '0);
    assign out_type  = head_rec.typ;
    assign out_pc    = head_rec.pc;
    assign out_addr  = head_rec.addr;
    assign out_data  = head_rec.data;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo with DEPTH=16, FILTER_ZERO=1, CNT_W=16.
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        grf_we = 1'b0;
    logic [31:0] grf_pc = '0;
    logic [4:0]  grf_addr = '0;
    logic [31:0] grf_wdata = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_pc = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_type;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    wb_trace_fifo #(.DEPTH(16), .FILTER_ZERO(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grf_ev(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wdata = d;
    endtask

    task automatic dm_ev(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wdata = d;
    endtask

    task automatic idle();
        grf_we = 1'b0; dm_we = 1'b0;
    endtask

    task automatic chk_rec(input string tag, input logic t, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] d);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".type"},  {31'd0, out_type},  {31'd0, t});
        chk({tag, ".pc"},    out_pc, pc);
        chk({tag, ".addr"},  out_addr, a);
        chk({tag, ".data"},  out_data, d);
    endtask

    initial begin
        // reset
        step(); step();
        reset = 1'b1;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.ovf",   {31'd0, overflow},  32'd0);
        chk("rst.drop",  {16'd0, drop_cnt},  32'd0);

        // single GRF event
        out_ready = 1'b1;
        grf_ev(32'h3000, 5'd8, 32'h1234);
        step(); idle();
        chk_rec("single", 1'b0, 32'h3000, 32'h8, 32'h1234);
        step();
        chk("single.empty", {31'd0, out_valid}, 32'd0);

        // simultaneous GRF and DM: GRF first
        grf_ev(32'h3008, 5'd9, 32'hAAAA);
        dm_ev(32'h300c, 32'h10, 32'h5);
        step(); idle();
        chk_rec("pair0", 1'b0, 32'h3008, 32'h9, 32'hAAAA);
        step();
        chk_rec("pair1", 1'b1, 32'h300c, 32'h10, 32'h5);
        step();
        chk("pair.empty", {31'd0, out_valid}, 32'd0);

        // write to $0 is filtered
        grf_ev(32'h3010, 5'd0, 32'hDEAD);
        step(); idle();
        chk("zero.valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("zero.valid2", {31'd0, out_valid}, 32'd0);
        chk("zero.ovf",   {31'd0, overflow},  32'd0);
        chk("zero.drop",  {16'd0, drop_cnt},  32'd0);

        // 17 events into a stalled queue: 17th dropped
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            grf_ev(32'h4000 + 32'(4 * i), 5'(i + 1), 32'(i));
            step();
        end
        idle();
        chk("fill.ovf",  {31'd0, overflow}, 32'd1);
        chk("fill.drop", {16'd0, drop_cnt}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_rec($sformatf("drain%0d", i), 1'b0, 32'h4000 + 32'(4 * i), 32'(i + 1), 32'(i));
            step();
        end
        chk("drain.empty", {31'd0, out_valid}, 32'd0);
        chk("drain.drop",  {16'd0, drop_cnt},  32'd1);

        // full queue with dequeue: GRF admitted, DM dropped
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            grf_ev(32'h5000 + 32'(4 * i), 5'(i + 1), 32'(100 + i));
            step();
        end
        idle();
        chk("full.drop0", {16'd0, drop_cnt}, 32'd1);
        out_ready = 1'b1;
        grf_ev(32'h6000, 5'd20, 32'hBEEF);
        dm_ev(32'h6004, 32'h40, 32'hCAFE);
        step(); idle();
        out_ready = 1'b0;
        chk("full.drop1", {16'd0, drop_cnt}, 32'd2);
        chk("full.ovf",   {31'd0, overflow}, 32'd1);
        chk_rec("full.head", 1'b0, 32'h5004, 32'd2, 32'd101);
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("full.data", out_data, 32'(100 + i));
            step();
        end
        chk_rec("full.last", 1'b0, 32'h6000, 32'd20, 32'hBEEF);
        step();
        chk("full.empty", {31'd0, out_valid}, 32'd0);

        // reset while holding 5 records
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dm_ev(32'h7000 + 32'(4 * i), 32'h100 + 32'(4 * i), 32'(200 + i));
            step();
        end
        idle();
        chk("pre.valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b0;
        grf_ev(32'h7100, 5'd7, 32'h999);
        step(); idle();
        reset = 1'b1;
        chk("mrst.valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.ovf",   {31'd0, overflow},  32'd0);
        chk("mrst.drop",  {16'd0, drop_cnt},  32'd0);
        out_ready = 1'b1;
        grf_ev(32'h7200, 5'd3, 32'h77);
        step(); idle();
        chk_rec("post", 1'b0, 32'h7200, 32'd3, 32'h77);
        step();
        chk("post.empty", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Observation stage directly downstream of the mips core.
- Captures every architectural write event the core commits: GRF write-back and DM store.
- Queues those events in program order and drains them one per cycle over a valid/ready port.
- The simulation bench consumes that port and prints the "@pc: $reg <= data" / "@pc: *addr <= data" trace, so trace emission is decoupled from core timing.

Parameters:
DEPTH, 16, number of event slots; power of two, >= 2
FILTER_ZERO, 1, when 1 GRF writes to register 0 are discarded (not queued, not counted as drops)
CNT_W, 16, width of the dropped-event counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge clears all state)
grf_we  input  1  GRF write event valid this cycle (W stage)
grf_pc  input  32  PC of the writing instruction
grf_addr  input  5  destination register
grf_wdata  input  32  written value
dm_we  input  1  DM store event valid this cycle (M stage)
dm_pc  input  32  PC of the storing instruction
dm_addr  input  32  word-aligned byte address
dm_wdata  input  32  stored word
out_valid  output  1  head record present
out_ready  input  1  consumer accepts head record this cycle
out_type  output  1  0 = GRF record, 1 = DM record
out_pc  output  32  record PC
out_addr  output  32  register number zero-extended, or DM address
out_data  output  32  record data
overflow  output  1  sticky: at least one event dropped since reset
drop_cnt  output  CNT_W  number of dropped events, saturating

Behaviour:
- Reset (reset==0 at clk edge):
  - Clears head, tail, count, overflow and drop_cnt.
  - Reset has priority over all same-cycle events; input events in that cycle are discarded.
  - A mid-drain reset discards all queued records.
- Storage and outputs:
  - Circular buffer of DEPTH records; head/tail pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
  - out_valid = (count != 0).
  - out_* reflect the head slot and are don't-care when out_valid==0; the bench must not sample them then.
- Dequeue: occurs when out_valid && out_ready at a clock edge; head advances by 1. out_ready while empty has no effect.
- Enqueue and ordering:
  - Up to 2 events are enqueued per cycle.
  - When both grf_we and dm_we are high, the GRF record is written first, then the DM record, because the W-stage instruction is older than the M-stage instruction.
  - A GRF event with FILTER_ZERO==1 and grf_addr==0 is not an event.
- Latency: an event presented at edge N is visible on out_* from cycle N+1 at the earliest, when the queue was empty before it.
- Free space this cycle = DEPTH - count + (dequeue this cycle ? 1 : 0).
  - Events are admitted in order (GRF then DM) while space remains; the rest are dropped.
  - Each dropped event sets overflow=1 and increments drop_cnt by 1 (by 2 if both are dropped).
  - drop_cnt saturates at 2^CNT_W-1.
- Simultaneous enqueue and dequeue:
  - Full queue with dequeue: one incoming event is admitted.
  - Empty queue with enqueue: no dequeue in that cycle, because out_valid was 0.
- count update: count_next = count + admitted - dequeued. Never exceeds DEPTH, never underflows.
- overflow clears only on reset.
- No combinational path from any input to out_valid or out_*.

Test Plan:
- Single GRF event (pc=0x3000, addr=8, data=0x1234) with out_ready=1 -> next cycle out_valid=1, type=0, addr=0x8, data=0x1234; following cycle out_valid=0.
- Same-cycle grf (pc=0x3008, addr=9) and dm (pc=0x300c, addr=0x10, data=5) -> two records in order GRF then DM over two ready cycles.
- GRF write to reg 0 with FILTER_ZERO=1 -> out_valid stays 0; overflow=0; drop_cnt=0.
- out_ready=0, issue 17 single events with DEPTH=16 -> count=16, 17th dropped, overflow=1, drop_cnt=1; drain yields the first 16 in order.
- Full queue, out_ready=1, simultaneous grf and dm events -> GRF admitted, DM dropped, drop_cnt increments by 1; count stays 16.
- Queue holding 5 records, assert reset=0 for one edge -> out_valid=0, overflow=0, drop_cnt=0 next cycle; a new event afterwards appears as the sole record.
